// File: rtl/decode_pkg.sv
// Shared RV32I/M decode encodings and the decoded-instruction bundle, used by decode, ALU and memory units.
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      EXT_NONE = 3'b000,
      EXT_I    = 3'b001,
      EXT_B    = 3'b010,
      EXT_J    = 3'b011,
      EXT_U    = 3'b100,
      EXT_S    = 3'b101
   } ext_op_t;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_BU = 3'b001;
   localparam logic [2:0] MEM_H  = 3'b010;
   localparam logic [2:0] MEM_HU = 3'b011;
   localparam logic [2:0] MEM_W  = 3'b100;

   localparam logic       ASRC_RS1  = 1'b0;
   localparam logic       ASRC_PC   = 1'b1;
   localparam logic [1:0] BSRC_RS2  = 2'b00;
   localparam logic [1:0] BSRC_IMM  = 2'b01;
   localparam logic [1:0] BSRC_FOUR = 2'b10;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SLL  = 5'b00001;
   localparam logic [4:0] ALU_SLT  = 5'b00010;
   localparam logic [4:0] ALU_SLTU = 5'b00011;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_SRL  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;
   localparam logic [4:0] ALU_AND  = 5'b00111;
   localparam logic [4:0] ALU_SUB  = 5'b01000;
   localparam logic [4:0] ALU_SRA  = 5'b01001;
   localparam logic [4:0] ALU_BEQ  = 5'b01010;
   localparam logic [4:0] ALU_BNE  = 5'b01011;
   localparam logic [4:0] ALU_BLT  = 5'b01100;
   localparam logic [4:0] ALU_BGE  = 5'b01101;
   localparam logic [4:0] ALU_BLTU = 5'b01110;
   localparam logic [4:0] ALU_BGEU = 5'b01111;
   localparam logic [4:0] ALU_LUI  = 5'b10000;
   // mul..remu occupy ALU_MUL + func3
   localparam logic [4:0] ALU_MUL  = 5'b10001;

   typedef struct packed {
      ext_op_t     ext_op;
      logic        reg_wr;
      logic        alua_src;
      logic [1:0]  alub_src;
      logic [4:0]  alu_ctr;
      logic        branch;
      logic        jump;
      logic        mem_to_reg;
      logic        mem_wr;
      logic [2:0]  mem_op;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        illegal;
   } bundle_t;

   localparam int BUNDLE_W = $bits(bundle_t);

   function automatic logic [31:0] imm_gen(input logic [31:0] inst, input ext_op_t ext);
      case (ext)
         EXT_I:   return {{20{inst[31]}}, inst[31:20]};
         EXT_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
         EXT_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         EXT_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         EXT_U:   return {inst[31:12], 12'h000};
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/inst_decoder.sv
// Purely combinational RV32I(+M) decoder producing the control/immediate bundle.
// Illegal encodings flag illegal and suppress every architectural side effect.
module inst_decoder
   import decode_pkg::*;
#(
   parameter int EN_M = 0
) (
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output bundle_t     dec
);

   logic [2:0] f3;
   logic [6:0] f7;
   logic       ill;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   always_comb begin
      dec            = '0;
      ill            = 1'b0;
      dec.ext_op     = EXT_NONE;
      dec.alua_src   = ASRC_RS1;
      dec.alub_src   = BSRC_RS2;
      dec.alu_ctr    = ALU_ADD;
      dec.mem_op     = MEM_B;
      dec.rs1        = inst[19:15];
      dec.rs2        = inst[24:20];
      dec.rd         = inst[11:7];
      dec.pc         = pc;
      case (inst[6:0])
         OPC_LUI: begin
            dec.ext_op = EXT_U; dec.reg_wr = 1'b1; dec.alub_src = BSRC_IMM; dec.alu_ctr = ALU_LUI;
         end
         OPC_AUIPC: begin
            dec.ext_op = EXT_U; dec.reg_wr = 1'b1; dec.alua_src = ASRC_PC; dec.alub_src = BSRC_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            dec.ext_op   = (inst[3]) ? EXT_J : EXT_I;
            dec.reg_wr   = 1'b1;
            dec.jump     = 1'b1;
            dec.alua_src = ASRC_PC;
            dec.alub_src = BSRC_FOUR;
            ill          = !inst[3] && (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.ext_op = EXT_B;
            dec.branch = 1'b1;
            case (f3)
               3'b000:  dec.alu_ctr = ALU_BEQ;
               3'b001:  dec.alu_ctr = ALU_BNE;
               3'b100:  dec.alu_ctr = ALU_BLT;
               3'b101:  dec.alu_ctr = ALU_BGE;
               3'b110:  dec.alu_ctr = ALU_BLTU;
               3'b111:  dec.alu_ctr = ALU_BGEU;
               default: ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.ext_op = EXT_I; dec.reg_wr = 1'b1; dec.mem_to_reg = 1'b1; dec.alub_src = BSRC_IMM;
            case (f3)
               3'b000:  dec.mem_op = MEM_B;
               3'b001:  dec.mem_op = MEM_H;
               3'b010:  dec.mem_op = MEM_W;
               3'b100:  dec.mem_op = MEM_BU;
               3'b101:  dec.mem_op = MEM_HU;
               default: ill = 1'b1;
            endcase
         end
         OPC_STORE: begin
            dec.ext_op = EXT_S; dec.mem_wr = 1'b1; dec.alub_src = BSRC_IMM;
            case (f3)
               3'b000:  dec.mem_op = MEM_B;
               3'b001:  dec.mem_op = MEM_H;
               3'b010:  dec.mem_op = MEM_W;
               default: ill = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            dec.ext_op = EXT_I; dec.reg_wr = 1'b1; dec.alub_src = BSRC_IMM;
            dec.alu_ctr = alu_of_f3(f3);
            // Shift-immediates reuse funct7; only inst[30] may be set, and only for srai
            if (f3 == 3'b001) ill = (f7 != 7'b0000000);
            if (f3 == 3'b101) begin
               if (f7 == 7'b0100000)      dec.alu_ctr = ALU_SRA;
               else if (f7 != 7'b0000000) ill = 1'b1;
            end
         end
         OPC_OP: begin
            dec.reg_wr = 1'b1;
            case (f7)
               7'b0000000: dec.alu_ctr = alu_of_f3(f3);
               7'b0100000: begin
                  if (f3 == 3'b000)      dec.alu_ctr = ALU_SUB;
                  else if (f3 == 3'b101) dec.alu_ctr = ALU_SRA;
                  else                   ill = 1'b1;
               end
               7'b0000001: begin
                  if (EN_M != 0) dec.alu_ctr = ALU_MUL + {2'b00, f3};
                  else           ill = 1'b1;
               end
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      dec.imm = imm_gen(inst, dec.ext_op);
      if (ill) begin
         dec.reg_wr = 1'b0;
         dec.mem_wr = 1'b0;
         dec.branch = 1'b0;
         dec.jump   = 1'b0;
      end
      dec.illegal = ill;
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: 1-cycle registered decode behind a 2-entry skid buffer.
// in_ready comes straight from the skid-valid flop, so it never depends on out_ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int EN_M     = 0,
   parameter int ALUCTR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [31:0]         in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                flush,
   output logic [2:0]          ExtOp,
   output logic                RegWr,
   output logic                ALUASrc,
   output logic [1:0]          ALUBSrc,
   output logic [ALUCTR_W-1:0] ALUCtr,
   output logic                Branch,
   output logic                Jump,
   output logic                MemtoReg,
   output logic                MemWr,
   output logic [2:0]          MemOp,
   output logic [31:0]         imm,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [31:0]         out_pc,
   output logic                illegal
);

   bundle_t               dec;
   bundle_t               out_q, out_d;
   logic [BUNDLE_W-1:0]   skid_q, skid_d;
   logic                  out_vld_q, out_vld_d;
   logic                  skid_vld_q, skid_vld_d;
   logic                  accept, out_free;

   inst_decoder #(.EN_M(EN_M)) u_inst_decoder (
      .inst (in_inst),
      .pc   (in_pc),
      .dec  (dec)
   );

   always_comb begin
      accept     = in_valid && !skid_vld_q;
      out_free   = !out_vld_q || out_ready;
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_free) begin
         // A full skid blocks accept, so it is the only candidate for the output slot
         if (skid_vld_q) begin
            out_d      = bundle_t'(skid_q);
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = accept;
            if (accept) out_d = dec;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign in_ready  = !skid_vld_q;
   assign out_valid = out_vld_q;
   assign ExtOp     = out_q.ext_op;
   assign RegWr     = out_q.reg_wr;
   assign ALUASrc   = out_q.alua_src;
   assign ALUBSrc   = out_q.alub_src;
   assign ALUCtr    = ALUCTR_W'(out_q.alu_ctr);
   assign Branch    = out_q.branch;
   assign Jump      = out_q.jump;
   assign MemtoReg  = out_q.mem_to_reg;
   assign MemWr     = out_q.mem_wr;
   assign MemOp     = out_q.mem_op;
   assign imm       = out_q.imm;
   assign rs1       = out_q.rs1;
   assign rs2       = out_q.rs2;
   assign rd        = out_q.rd;
   assign out_pc    = out_q.pc;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: EN_M=1 instance fully checked, EN_M=0 twin checked for M-illegal handling.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, flush;
   logic [31:0] in_inst, in_pc;

   logic        in_ready, out_valid, RegWr, ALUASrc, Branch, Jump, MemtoReg, MemWr, illegal;
   logic [2:0]  ExtOp, MemOp;
   logic [1:0]  ALUBSrc;
   logic [4:0]  ALUCtr, rs1, rs2, rd;
   logic [31:0] imm, out_pc;

   logic        z_in_ready, z_out_valid, z_RegWr, z_ALUASrc, z_Branch, z_Jump, z_MemtoReg, z_MemWr, z_illegal;
   logic [2:0]  z_ExtOp, z_MemOp;
   logic [1:0]  z_ALUBSrc;
   logic [4:0]  z_ALUCtr, z_rs1, z_rs2, z_rd;
   logic [31:0] z_imm, z_out_pc;

   always #5 clk = ~clk;

   decode_stage #(.EN_M(1), .ALUCTR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .ExtOp(ExtOp), .RegWr(RegWr), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUCtr(ALUCtr),
      .Branch(Branch), .Jump(Jump), .MemtoReg(MemtoReg), .MemWr(MemWr), .MemOp(MemOp),
      .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .out_pc(out_pc), .illegal(illegal)
   );

   decode_stage #(.EN_M(0), .ALUCTR_W(5)) dut_nom (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(z_out_valid), .out_ready(out_ready), .flush(flush),
      .ExtOp(z_ExtOp), .RegWr(z_RegWr), .ALUASrc(z_ALUASrc), .ALUBSrc(z_ALUBSrc), .ALUCtr(z_ALUCtr),
      .Branch(z_Branch), .Jump(z_Jump), .MemtoReg(z_MemtoReg), .MemWr(z_MemWr), .MemOp(z_MemOp),
      .imm(z_imm), .rs1(z_rs1), .rs2(z_rs2), .rd(z_rd), .out_pc(z_out_pc), .illegal(z_illegal)
   );

   typedef struct packed {
      logic [2:0]  ext;
      logic        regwr;
      logic        asrc;
      logic [1:0]  bsrc;
      logic [4:0]  aluctr;
      logic        br;
      logic        jmp;
      logic        m2r;
      logic        mwr;
      logic [2:0]  mop;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        ill;
   } v_t;

   typedef struct {
      v_t   e;
      v_t   m;
      logic ill0;
      logic rw0;
   } sb_t;

   sb_t         sb_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          n_out = 0;
   int          cyc   = 0;
   logic [31:0] pc_nxt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic v_t act_main();
      v_t a;
      a.ext = ExtOp; a.regwr = RegWr; a.asrc = ALUASrc; a.bsrc = ALUBSrc; a.aluctr = ALUCtr;
      a.br = Branch; a.jmp = Jump; a.m2r = MemtoReg; a.mwr = MemWr; a.mop = MemOp;
      a.imm = imm; a.rs1 = rs1; a.rs2 = rs2; a.rd = rd; a.pc = out_pc; a.ill = illegal;
      return a;
   endfunction

   function automatic v_t ctl(input logic [2:0] ext, input logic rw, input logic as, input logic [1:0] bs,
                              input logic [4:0] alu, input logic br, input logic jp, input logic m2r, input logic mw);
      v_t v = '0;
      v.ext = ext; v.regwr = rw; v.asrc = as; v.bsrc = bs; v.aluctr = alu;
      v.br = br; v.jmp = jp; v.m2r = m2r; v.mwr = mw;
      return v;
   endfunction

   function automatic v_t cmask(input bit mop_c, input bit imm_c, input bit rs1_c, input bit rs2_c, input bit rd_c);
      v_t m = '0;
      m.ext = '1; m.regwr = 1'b1; m.asrc = 1'b1; m.bsrc = '1; m.aluctr = '1;
      m.br = 1'b1; m.jmp = 1'b1; m.m2r = 1'b1; m.mwr = 1'b1; m.ill = 1'b1; m.pc = '1;
      if (mop_c) m.mop = '1;
      if (imm_c) m.imm = '1;
      if (rs1_c) m.rs1 = '1;
      if (rs2_c) m.rs2 = '1;
      if (rd_c)  m.rd  = '1;
      return m;
   endfunction

   function automatic v_t imask();
      v_t m = '0;
      m.regwr = 1'b1; m.mwr = 1'b1; m.br = 1'b1; m.jmp = 1'b1; m.ill = 1'b1; m.pc = '1;
      return m;
   endfunction

   // Present one instruction and wait (bounded) for it to be accepted; expected entry queued on acceptance.
   task automatic send(input logic [31:0] inst, input v_t e, input v_t m, input logic ill0, input logic rw0);
      sb_t s;
      bit  acc;
      int  n;
      e.pc     = pc_nxt;
      in_inst  = inst;
      in_pc    = pc_nxt;
      in_valid = 1'b1;
      pc_nxt   = pc_nxt + 32'd4;
      s.e = e; s.m = m; s.ill0 = ill0; s.rw0 = rw0;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 40) begin
         @(negedge clk);
         acc = in_ready && !flush && !rst;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) sb_q.push_back(s);
      else begin
         n_chk++; n_err++;
         $display("FAIL send_timeout: inst %h not accepted within 40 cycles", inst);
      end
   endtask

   task automatic sv(input logic [31:0] inst, input v_t e, input v_t m);
      send(inst, e, m, e.ill, e.regwr);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
      chk({tag, "_bundle_zero"}, 128'(act_main()), 128'(0));
      chk({tag, "_nom_out_valid"}, 128'(z_out_valid), 128'(1'b0));
   endtask

   function automatic v_t addi_exp(input logic [31:0] k, input logic [4:0] rdn);
      v_t e = ctl(3'b001, 1'b1, 1'b0, 2'b01, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
      e.imm = k; e.rs1 = 5'd0; e.rd = rdn;
      return e;
   endfunction

   // Monitor: every completed output handshake must match the oldest queued expectation.
   initial begin
      sb_t s;
      forever begin
         @(negedge clk);
         if (!rst && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
            end else begin
               s = sb_q.pop_front();
               n_out++;
               chk("bundle", 128'(act_main() & s.m), 128'(s.e & s.m));
               chk("nom_variant", 128'({z_illegal, z_RegWr, (s.ill0 ? {z_MemWr, z_Branch, z_Jump} : 3'b000)}),
                   128'({s.ill0, s.rw0, 3'b000}));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      v_t   e;
      int   c0, n0;
      logic [31:0] p;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      in_inst = 32'h0; in_pc = 32'h0; pc_nxt = 32'h0000_0100;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_cleared("reset");

      // Streaming at full rate with out_ready high
      c0 = cyc;
      p  = pc_nxt;
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      chk("addi_latency_valid", 128'(out_valid), 128'(1'b1));
      chk("addi_latency_pc", 128'(out_pc), 128'(p));
      e = ctl(3'b101, 0, 0, 2'b01, 5'b00000, 0, 0, 0, 1); e.mop = 3'b100; e.imm = 32'hFFFF_FFFC; e.rs1 = 2; e.rs2 = 1;
      sv(32'hFE11_2E23, e, cmask(1, 1, 1, 1, 0));
      e = ctl(3'b000, 1, 0, 2'b00, 5'b10001, 0, 0, 0, 0); e.imm = 0; e.rs1 = 1; e.rs2 = 2; e.rd = 3;
      send(32'h0220_81B3, e, cmask(0, 1, 1, 1, 1), 1'b1, 1'b0);
      e = ctl(3'b100, 1, 0, 2'b01, 5'b10000, 0, 0, 0, 0); e.imm = 32'h1234_5000; e.rd = 5;
      sv(32'h1234_52B7, e, cmask(0, 1, 0, 0, 1));
      e = ctl(3'b100, 1, 1, 2'b01, 5'b00000, 0, 0, 0, 0); e.imm = 32'h0000_1000; e.rd = 6;
      sv(32'h0000_1317, e, cmask(0, 1, 0, 0, 1));
      e = ctl(3'b011, 1, 1, 2'b10, 5'b00000, 0, 1, 0, 0); e.imm = 32'hFFFF_FFF8; e.rd = 1;
      sv(32'hFF9F_F0EF, e, cmask(0, 1, 0, 0, 1));
      e = ctl(3'b001, 1, 1, 2'b10, 5'b00000, 0, 1, 0, 0); e.imm = 0; e.rs1 = 1; e.rd = 0;
      sv(32'h0000_8067, e, cmask(0, 1, 1, 0, 1));
      e = ctl(3'b010, 0, 0, 2'b00, 5'b01010, 1, 0, 0, 0); e.imm = 32'd8; e.rs1 = 1; e.rs2 = 2;
      sv(32'h0020_8463, e, cmask(0, 1, 1, 1, 0));
      e = ctl(3'b010, 0, 0, 2'b00, 5'b01011, 1, 0, 0, 0); e.imm = 32'hFFFF_FFFC; e.rs1 = 1; e.rs2 = 2;
      sv(32'hFE20_9EE3, e, cmask(0, 1, 1, 1, 0));
      e = ctl(3'b001, 1, 0, 2'b01, 5'b00000, 0, 0, 1, 0); e.mop = 3'b001; e.imm = 32'd3; e.rs1 = 8; e.rd = 7;
      sv(32'h0034_4383, e, cmask(1, 1, 1, 0, 1));
      e = ctl(3'b001, 1, 0, 2'b01, 5'b01001, 0, 0, 0, 0); e.rs1 = 9; e.rd = 9;
      sv(32'h4034_D493, e, cmask(0, 0, 1, 0, 1));
      e = ctl(3'b000, 1, 0, 2'b00, 5'b01000, 0, 0, 0, 0); e.imm = 0; e.rs1 = 1; e.rs2 = 2; e.rd = 3;
      sv(32'h4020_81B3, e, cmask(0, 1, 1, 1, 1));
      e = ctl(3'b001, 1, 0, 2'b01, 5'b00100, 0, 0, 0, 0); e.imm = 32'hFFFF_FFFF; e.rs1 = 1; e.rd = 1;
      sv(32'hFFF0_C093, e, cmask(0, 1, 1, 0, 1));
      e = '0; e.ill = 1'b1;
      sv(32'h0000_007F, e, imask());
      sv(32'h0020_A063, e, imask());
      chk("throughput_cycles", 128'(cyc - c0), 128'(15));
      idle(3);

      // Stall: first word held on output, second in skid, third refused until release
      out_ready = 1'b0;
      n0 = n_out;
      p  = pc_nxt;
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      sv(32'h0060_0113, addi_exp(32'd6, 5'd2), cmask(0, 1, 1, 0, 1));
      chk("skid_full_in_ready", 128'(in_ready), 128'(1'b0));
      in_inst = 32'h0070_0193; in_pc = pc_nxt; in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
      chk("stall_out_valid", 128'(out_valid), 128'(1'b1));
      chk("stall_held_pc", 128'(out_pc), 128'(p));
      chk("stall_held_rd", 128'(rd), 128'(5'd1));
      out_ready = 1'b1;
      sv(32'h0070_0193, addi_exp(32'd7, 5'd3), cmask(0, 1, 1, 0, 1));
      idle(4);
      chk("stall_release_count", 128'(n_out - n0), 128'(3));

      // Flush with both entries full and a word offered
      out_ready = 1'b0;
      n0 = n_out;
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      sv(32'h0060_0113, addi_exp(32'd6, 5'd2), cmask(0, 1, 1, 0, 1));
      in_inst = 32'h0070_0193; in_pc = pc_nxt; pc_nxt = pc_nxt + 32'd4; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      sb_q.delete();
      chk("flush_full_out_valid", 128'(out_valid), 128'(1'b0));
      chk("flush_full_in_ready", 128'(in_ready), 128'(1'b1));
      // Flush while an input is actually accepted in the same cycle
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      in_inst = 32'h0060_0113; in_pc = pc_nxt; pc_nxt = pc_nxt + 32'd4; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      sb_q.delete();
      chk("flush_accept_out_valid", 128'(out_valid), 128'(1'b0));
      chk("flush_accept_in_ready", 128'(in_ready), 128'(1'b1));
      out_ready = 1'b1;
      idle(4);
      chk("flush_no_output", 128'(n_out - n0), 128'(0));

      // Reset pulse in the middle of a stall
      out_ready = 1'b0;
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      sv(32'h0060_0113, addi_exp(32'd6, 5'd2), cmask(0, 1, 1, 0, 1));
      in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      check_cleared("midstall_reset");
      n0 = n_out;
      p  = pc_nxt;
      sv(32'h0050_0093, addi_exp(32'd5, 5'd1), cmask(0, 1, 1, 0, 1));
      chk("post_reset_latency_valid", 128'(out_valid), 128'(1'b1));
      chk("post_reset_latency_pc", 128'(out_pc), 128'(p));
      idle(3);
      chk("post_reset_count", 128'(n_out - n0), 128'(1));

      idle(5);
      chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
